// File: rtl/regfile_mp.sv
// regfile_mp: two-write / two-read register file with a pending-destination
// scoreboard and a zeroing sweep that runs after every reset.

// One read lane: bounds/zero checks, optional write forwarding, busy lookup.
module regfile_mp_rport #(
  parameter int DSIZE  = 32,
  parameter int ASIZE  = 5,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic                       run,
  input  logic [ASIZE-1:0]           raddr,
  input  logic [NREG-1:0][DSIZE-1:0] regs,
  input  logic [NREG-1:0]            busy,
  input  logic                       we1,
  input  logic [ASIZE-1:0]           waddr1,
  input  logic [DSIZE-1:0]           wdata1,
  input  logic                       we2,
  input  logic [ASIZE-1:0]           waddr2,
  input  logic [DSIZE-1:0]           wdata2,
  output logic [DSIZE-1:0]           rdata,
  output logic                       busyo
);
  localparam logic [31:0] NREG_L = 32'(NREG);

  logic ok, hit1, hit2;

  // Forwarding hits only exist when bypass is enabled; port 1 outranks port 2.
  always_comb begin
    ok    = run && (raddr != '0) && (32'(raddr) < NREG_L);
    hit1  = (BYPASS != 0) && we1 && (waddr1 == raddr);
    hit2  = (BYPASS != 0) && we2 && (waddr2 == raddr);
    rdata = '0;
    if (ok) begin
      if (hit1)      rdata = wdata1;
      else if (hit2) rdata = wdata2;
      else           rdata = regs[raddr];
    end
    busyo = ok && busy[raddr] && !hit1 && !hit2;
  end
endmodule

module regfile_mp #(
  parameter int DSIZE  = 32,
  parameter int ASIZE  = 5,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen1,
  input  logic [ASIZE-1:0] waddr1,
  input  logic [DSIZE-1:0] wdata1,
  input  logic             wen2,
  input  logic [ASIZE-1:0] waddr2,
  input  logic [DSIZE-1:0] wdata2,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  input  logic             issue_en,
  input  logic [ASIZE-1:0] issue_addr,
  output logic [DSIZE-1:0] rdata1,
  output logic [DSIZE-1:0] rdata2,
  output logic             busy1,
  output logic             busy2,
  output logic             ready
);
  localparam logic [31:0] NREG_L = 32'(NREG);

  typedef enum logic {INIT, RUN} state_t;

  state_t                     state;
  logic [ASIZE-1:0]           cnt;
  logic [NREG-1:0][DSIZE-1:0] regdata;
  logic [NREG-1:0]            busy;
  logic                       run, we1, we2, iss;

  logic [1:0][ASIZE-1:0] raddr_v;
  logic [1:0][DSIZE-1:0] rdata_v;
  logic [1:0]            busy_v;

  function automatic logic addr_ok(input logic [ASIZE-1:0] a);
    return (a != '0) && (32'(a) < NREG_L);
  endfunction

  // Effective write/issue qualifiers: only in RUN, never to r0 or out of range.
  always_comb begin
    run = (state == RUN);
    we1 = run && wen1 && addr_ok(waddr1);
    we2 = run && wen2 && addr_ok(waddr2);
    iss = run && issue_en && addr_ok(issue_addr);
  end

  // Init sweep FSM; ready is registered and mirrors the RUN state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == ASIZE'(NREG - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase
    end
  end

  // Storage: sweep zeroes one entry per INIT cycle; port 1 written last so it wins.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      regdata[cnt] <= '0;
    end else begin
      if (we2) regdata[waddr2] <= wdata2;
      if (we1) regdata[waddr1] <= wdata1;
    end
  end

  // Pending scoreboard: issue sets, effective write clears, set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (iss && (issue_addr == ASIZE'(i)))
          busy[i] <= 1'b1;
        else if ((we1 && (waddr1 == ASIZE'(i))) || (we2 && (waddr2 == ASIZE'(i))))
          busy[i] <= 1'b0;
      end
    end
  end

  assign raddr_v = {raddr2, raddr1};

  for (genvar g = 0; g < 2; g++) begin : g_rp
    regfile_mp_rport #(
      .DSIZE(DSIZE), .ASIZE(ASIZE), .NREG(NREG), .BYPASS(BYPASS)
    ) u_rp (
      .run    (run),
      .raddr  (raddr_v[g]),
      .regs   (regdata),
      .busy   (busy),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .we2    (we2),
      .waddr2 (waddr2),
      .wdata2 (wdata2),
      .rdata  (rdata_v[g]),
      .busyo  (busy_v[g])
    );
  end

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];
  assign busy1  = busy_v[0];
  assign busy2  = busy_v[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: behavioural model feeds a queue of expected outputs,
// each scenario task pops and compares once outputs have settled.
module tb_regfile_mp;
  localparam int DSIZE = 32, ASIZE = 5, NREG = 32, BYPASS = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, wen1, wen2, issue_en, busy1, busy2, ready;
  logic [ASIZE-1:0] waddr1, waddr2, raddr1, raddr2, issue_addr;
  logic [DSIZE-1:0] wdata1, wdata2, rdata1, rdata2;

  regfile_mp #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NREG(NREG), .BYPASS(BYPASS)) dut (
    .clk(clk), .rst(rst),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .wen2(wen2), .waddr2(waddr2), .wdata2(wdata2),
    .raddr1(raddr1), .raddr2(raddr2),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  typedef struct { logic [31:0] r1, r2; logic b1, b2, rdy; } exp_t;
  exp_t sbq[$];

  logic [31:0]     m_regs [NREG];
  logic [NREG-1:0] m_busy;
  bit              m_run;
  int              m_cnt;
  int              total = 0, bad = 0;

  function automatic bit mv(input int a);
    return (a != 0) && (a < NREG);
  endfunction

  function automatic logic [31:0] mrd(input int ra, input bit e1, input int a1,
      input logic [31:0] d1, input bit e2, input int a2, input logic [31:0] d2);
    if (!m_run || !mv(ra)) return 32'h0;
    if (BYPASS != 0 && e1 && a1 == ra) return d1;
    if (BYPASS != 0 && e2 && a2 == ra) return d2;
    return m_regs[ra];
  endfunction

  function automatic logic mbz(input int ra, input bit e1, input int a1, input bit e2, input int a2);
    if (!m_run || !mv(ra)) return 1'b0;
    if (BYPASS != 0 && ((e1 && a1 == ra) || (e2 && a2 == ra))) return 1'b0;
    return m_busy[ra];
  endfunction

  // Drive one cycle at the negedge, push the expected outputs, advance the model.
  task automatic step(input logic r, input logic w1, input int a1, input logic [31:0] d1,
                      input logic w2, input int a2, input logic [31:0] d2,
                      input int ra1, input int ra2, input logic is, input int ia);
    exp_t e;
    bit e1, e2;
    @(negedge clk);
    rst = r; wen1 = w1; waddr1 = a1[ASIZE-1:0]; wdata1 = d1;
    wen2 = w2; waddr2 = a2[ASIZE-1:0]; wdata2 = d2;
    raddr1 = ra1[ASIZE-1:0]; raddr2 = ra2[ASIZE-1:0];
    issue_en = is; issue_addr = ia[ASIZE-1:0];
    e1 = m_run && w1 && mv(a1);
    e2 = m_run && w2 && mv(a2);
    e.r1 = mrd(ra1, e1, a1, d1, e2, a2, d2);
    e.r2 = mrd(ra2, e1, a1, d1, e2, a2, d2);
    e.b1 = mbz(ra1, e1, a1, e2, a2);
    e.b2 = mbz(ra2, e1, a1, e2, a2);
    e.rdy = m_run;
    sbq.push_back(e);
    if (r) begin
      m_run = 0; m_cnt = 0; m_busy = '0;
    end else if (!m_run) begin
      m_regs[m_cnt] = 32'h0;
      if (m_cnt == NREG - 1) m_run = 1;
      m_cnt++;
    end else begin
      if (e2) m_regs[a2] = d2;
      if (e1) m_regs[a1] = d1;
      if (e1) m_busy[a1] = 1'b0;
      if (e2) m_busy[a2] = 1'b0;
      if (is && mv(ia)) m_busy[ia] = 1'b1;
    end
    #2;
  endtask

  task automatic test_reset();
    exp_t e;
    int first = -1;
    @(negedge clk);
    rst = 1; wen1 = 0; wen2 = 0; issue_en = 0;
    waddr1 = '0; waddr2 = '0; wdata1 = '0; wdata2 = '0;
    raddr1 = '0; raddr2 = '0; issue_addr = '0;
    repeat (2) @(posedge clk);
    m_run = 0; m_cnt = 0; m_busy = '0;
    step(1, 0, 0, 0, 0, 0, 0, 7, 4, 0, 0);
    e = sbq.pop_front(); total++;
    if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
      bad++; $display("FAIL reset_hold got %h %h %b%b%b want %h %h %b%b%b",
        rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
    end
    for (int c = 0; c < 34; c++) begin
      // writes/issues during INIT must be ignored
      step(0, 1, 4, 32'hFFFF_FFFF, 1, 7, 32'h1234_5678, 7, 4, 1, 4);
      e = sbq.pop_front(); total++;
      if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
        bad++; $display("FAIL init_sweep c=%0d got %h %h %b%b%b want %h %h %b%b%b", c,
          rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
      end
      if (ready === 1'b1 && first < 0) first = c;
    end
    total++;
    if (first !== 32) begin
      bad++; $display("FAIL ready_latency got %0d want 32", first);
    end
  endtask

  task automatic test_write_bypass();
    exp_t e;
    step(0, 1, 3, 32'hA5A5_A5A5, 0, 0, 0, 3, 3, 0, 0);
    e = sbq.pop_front(); total++;
    if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
      bad++; $display("FAIL bypass_model got %h %h %b%b%b want %h %h %b%b%b",
        rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
    end
    total++;
    if (rdata1 !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL bypass_same_cycle got %h want a5a5a5a5", rdata1);
    end
    step(0, 0, 0, 0, 1, 12, 32'h0000_0C0C, 3, 12, 0, 0);
    e = sbq.pop_front(); total++;
    if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
      bad++; $display("FAIL write_persist got %h %h %b%b%b want %h %h %b%b%b",
        rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
    end
    total++;
    if (rdata2 !== 32'h0000_0C0C) begin
      bad++; $display("FAIL bypass_port2 got %h want 00000c0c", rdata2);
    end
  endtask

  task automatic test_dual_write();
    exp_t e;
    step(0, 1, 9, 32'h11, 1, 9, 32'h22, 9, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 9, 12, 0, 0);
    step(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    for (int k = 0; k < 4; k++) begin
      // only the last sample remains in the queue when outputs are current
      if (k < 3) begin void'(sbq.pop_front()); continue; end
      e = sbq.pop_front(); total++;
      if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
        bad++; $display("FAIL dual_write got %h %h %b%b%b want %h %h %b%b%b",
          rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
      end
    end
    total++;
    if (rdata2 !== 32'h11) begin
      bad++; $display("FAIL port1_wins got %h want 00000011", rdata2);
    end
    total++;
    if (rdata1 !== 32'h0) begin
      bad++; $display("FAIL r0_zero got %h want 00000000", rdata1);
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [4:0] want [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: step(0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 5);
        1: step(0, 0, 0, 0, 1, 5, 32'h55, 5, 0, 1, 5);
        2: step(0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0);
        3: step(0, 1, 5, 32'h66, 0, 0, 0, 5, 0, 0, 0);
        default: step(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
      endcase
      e = sbq.pop_front(); total++;
      if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
        bad++; $display("FAIL scoreboard k=%0d got %h %h %b%b%b want %h %h %b%b%b", k,
          rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
      end
      total++;
      if (busy1 !== want[k][0] || busy2 !== 1'b0) begin
        bad++; $display("FAIL busy_seq k=%0d got %b%b want %b0", k, busy1, busy2, want[k][0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int first = -1;
    step(1, 0, 0, 0, 0, 0, 0, 3, 6, 0, 0);
    void'(sbq.pop_front());
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 0, 0, 0, 0, 6, 3, 1, 6);
      e = sbq.pop_front(); total++;
      if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
        bad++; $display("FAIL partial_sweep c=%0d got %h %h %b%b%b want %h %h %b%b%b", c,
          rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
      end
    end
    step(1, 0, 0, 0, 0, 0, 0, 6, 3, 1, 6);
    void'(sbq.pop_front());
    for (int c = 0; c < 36; c++) begin
      step(0, 0, 0, 0, 0, 0, 0, 6, 3, !m_run, 6);
      e = sbq.pop_front(); total++;
      if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
        bad++; $display("FAIL resweep c=%0d got %h %h %b%b%b want %h %h %b%b%b", c,
          rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
      end
      if (ready === 1'b1 && first < 0) first = c;
    end
    total++;
    if (first !== 32) begin
      bad++; $display("FAIL restart_latency got %0d want 32", first);
    end
    total++;
    if (busy1 !== 1'b0 || rdata2 !== 32'h0) begin
      bad++; $display("FAIL init_issue_ignored got busy=%b r3=%h want 0 0", busy1, rdata2);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 60; c++) begin
      step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      e = sbq.pop_front(); total++;
      if ({rdata1, rdata2, busy1, busy2, ready} !== {e.r1, e.r2, e.b1, e.b2, e.rdy}) begin
        bad++; $display("FAIL b2b c=%0d got %h %h %b%b%b want %h %h %b%b%b", c,
          rdata1, rdata2, busy1, busy2, ready, e.r1, e.r2, e.b1, e.b2, e.rdy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
    test_reset();
    test_write_bypass();
    test_dual_write();
    test_scoreboard();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
